// File: rtl/nrf_link_sequencer_pkg.sv
// nrf_defs: shared definitions for the nRF24L01 PTX link sequencer.
//   - SPI command opcodes and register addresses used by the sequencer
//   - STATUS bit positions (TX_DS, MAX_RT)
//   - sequencer and framer state encodings
//   - helpers: W_REGISTER command builder, saturating increment, init table
package nrf_defs;

    localparam logic [7:0] CMD_W_REGISTER   = 8'h20;
    localparam logic [7:0] CMD_W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] CMD_FLUSH_TX     = 8'hE1;
    localparam logic [7:0] CMD_NOP          = 8'hFF;

    localparam logic [4:0] REG_CONFIG     = 5'h00;
    localparam logic [4:0] REG_EN_AA      = 5'h01;
    localparam logic [4:0] REG_SETUP_RETR = 5'h04;
    localparam logic [4:0] REG_RF_CH      = 5'h05;
    localparam logic [4:0] REG_RF_SETUP   = 5'h06;
    localparam logic [4:0] REG_STATUS     = 5'h07;

    localparam int STATUS_TX_DS  = 5;
    localparam int STATUS_MAX_RT = 4;

    // Six two-byte register writes followed by a one-byte FLUSH_TX.
    localparam int INIT_STEPS = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_XFER,
        S_PWRUP_WAIT,
        S_READY,
        S_TX_XFER,
        S_CE_PULSE,
        S_POLL,
        S_CLEAR,
        S_REPORT
    } seq_state_e;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LOAD,
        F_WAIT
    } frm_state_e;

    function automatic logic [7:0] w_reg(input logic [4:0] addr);
        return CMD_W_REGISTER | {3'b000, addr};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Byte of init transaction 'step'; cmd selects the command byte,
    // otherwise the data byte.
    function automatic logic [7:0] init_byte(input logic [2:0] step,
                                             input logic       cmd,
                                             input logic [7:0] rf_ch);
        logic [7:0] b;
        case (step)
            3'd0:    b = cmd ? w_reg(REG_CONFIG)     : 8'h0E;
            3'd1:    b = cmd ? w_reg(REG_EN_AA)      : 8'h01;
            3'd2:    b = cmd ? w_reg(REG_SETUP_RETR) : 8'h2F;
            3'd3:    b = cmd ? w_reg(REG_RF_CH)      : rf_ch;
            3'd4:    b = cmd ? w_reg(REG_RF_SETUP)   : 8'h06;
            3'd5:    b = cmd ? w_reg(REG_STATUS)     : 8'h70;
            default: b = CMD_FLUSH_TX;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nrf_spi_framer.sv
// nrf_spi_framer: frames one SPI transaction of len_i bytes.
//   go_i/len_i/ready_o   transaction request (accepted when ready_o=1)
//   idx_o/byte_i         byte source: caller presents byte idx_o on byte_i
//   done_o               pulse on the spi_done that ends the transaction
//   first_done_o         pulse on the spi_done of byte 0 (STATUS byte)
//   csn_o                chip select, falls one cycle before the first start,
//                        rises the cycle after the last done, then stays
//                        high for CSN_GAP_CYCLES
//   spi_start_o/spi_data_o/spi_done_i  byte handshake with the SPI engine
module nrf_spi_framer
    import nrf_defs::*;
#(
    parameter int CSN_GAP_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       go_i,
    input  logic [5:0] len_i,
    input  logic [7:0] byte_i,
    output logic [5:0] idx_o,
    output logic       ready_o,
    output logic       done_o,
    output logic       first_done_o,
    output logic       csn_o,
    output logic       spi_start_o,
    output logic [7:0] spi_data_o,
    input  logic       spi_done_i
);

    // Loaded on the csn rise; ready_o needs it at zero, which gives
    // exactly CSN_GAP_CYCLES high cycles before the next fall.
    localparam logic [7:0] GAP_LOAD = (CSN_GAP_CYCLES > 0) ? 8'(CSN_GAP_CYCLES - 1) : 8'd0;

    frm_state_e state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] len_q, len_d;
    logic [7:0] gap_q, gap_d;
    logic       csn_q, csn_d;
    logic       start_q, start_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= F_IDLE;
            idx_q   <= 6'd0;
            len_q   <= 6'd0;
            gap_q   <= 8'd0;
            csn_q   <= 1'b1;
            start_q <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            csn_q   <= csn_d;
            start_q <= start_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        csn_d        = csn_q;
        start_d      = 1'b0;
        data_d       = data_q;
        gap_d        = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;
        done_o       = 1'b0;
        first_done_o = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (go_i && gap_q == 8'd0) begin
                    csn_d   = 1'b0;
                    idx_d   = 6'd0;
                    len_d   = (len_i == 6'd0) ? 6'd1 : len_i;
                    state_d = F_LOAD;
                end
            end
            F_LOAD: begin
                start_d = 1'b1;
                data_d  = byte_i;
                state_d = F_WAIT;
            end
            F_WAIT: begin
                // spi_done is only honoured here, while a byte is pending.
                if (spi_done_i) begin
                    first_done_o = (idx_q == 6'd0);
                    if (idx_q == len_q - 6'd1) begin
                        csn_d   = 1'b1;
                        gap_d   = GAP_LOAD;
                        done_o  = 1'b1;
                        state_d = F_IDLE;
                    end else begin
                        idx_d   = (idx_q == 6'h3F) ? idx_q : idx_q + 6'd1;
                        state_d = F_LOAD;
                    end
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    assign ready_o     = (state_q == F_IDLE) && (gap_q == 8'd0);
    assign idx_o       = idx_q;
    assign csn_o       = csn_q;
    assign spi_start_o = start_q;
    assign spi_data_o  = data_q;

endmodule

// File: rtl/nrf_link_sequencer.sv
// nrf_link_sequencer: command-level sequencer for one nRF24L01 in PTX mode.
//   clk_10, rst (async, active low)
//   init_req / tx_req + tx_data   requests (tx_req honoured only in READY)
//   ready, busy, tx_ok, tx_fail   status; tx_ok/tx_fail are one-cycle pulses
//   status_q                      STATUS byte from the last command byte
//   spi_data_out/spi_start/spi_done/spi_data_in  byte engine handshake
//   csn, ce                       device control pins
module nrf_link_sequencer
    import nrf_defs::*;
#(
    parameter int         PAYLOAD_LEN       = 4,
    parameter logic [7:0] RF_CHANNEL        = 8'd76,
    parameter int         CE_PULSE_CYCLES   = 150,
    parameter int         PWRUP_WAIT_CYCLES = 15000,
    parameter int         CSN_GAP_CYCLES    = 2,
    parameter int         POLL_TIMEOUT      = 65535
) (
    input  logic                     clk_10,
    input  logic                     rst,
    input  logic                     init_req,
    input  logic                     tx_req,
    input  logic [8*PAYLOAD_LEN-1:0] tx_data,
    output logic                     ready,
    output logic                     busy,
    output logic                     tx_ok,
    output logic                     tx_fail,
    output logic [7:0]               status_q,
    output logic [7:0]               spi_data_out,
    output logic                     spi_start,
    input  logic                     spi_done,
    input  logic [7:0]               spi_data_in,
    output logic                     csn,
    output logic                     ce
);

    localparam logic [15:0] PWRUP_LAST = 16'(PWRUP_WAIT_CYCLES - 1);
    localparam logic [15:0] CE_LAST    = 16'(CE_PULSE_CYCLES - 1);
    localparam logic [15:0] POLL_MAX   = 16'(POLL_TIMEOUT);
    localparam logic [2:0]  INIT_LAST  = 3'(INIT_STEPS - 1);

    seq_state_e               state_q, state_d;
    logic [2:0]               step_q, step_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [15:0]              poll_q, poll_d;
    logic                     fail_q, fail_d;
    logic                     ce_q, ce_d;
    logic [7:0]               stat_q, stat_d;
    logic [8*PAYLOAD_LEN-1:0] payload_q, payload_d;

    logic       frm_go;
    logic [5:0] frm_len;
    logic [7:0] frm_byte;
    logic [5:0] frm_idx;
    logic       frm_ready;
    logic       frm_done;
    logic       frm_first;

    nrf_spi_framer #(
        .CSN_GAP_CYCLES(CSN_GAP_CYCLES)
    ) u_framer (
        .clk_i       (clk_10),
        .rst_ni      (rst),
        .go_i        (frm_go),
        .len_i       (frm_len),
        .byte_i      (frm_byte),
        .idx_o       (frm_idx),
        .ready_o     (frm_ready),
        .done_o      (frm_done),
        .first_done_o(frm_first),
        .csn_o       (csn),
        .spi_start_o (spi_start),
        .spi_data_o  (spi_data_out),
        .spi_done_i  (spi_done)
    );

    always_ff @(posedge clk_10 or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            step_q    <= 3'd0;
            cnt_q     <= 16'd0;
            poll_q    <= 16'd0;
            fail_q    <= 1'b0;
            ce_q      <= 1'b0;
            stat_q    <= 8'd0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            fail_q    <= fail_d;
            ce_q      <= ce_d;
            stat_q    <= stat_d;
            payload_q <= payload_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        fail_d    = fail_q;
        ce_d      = ce_q;
        payload_d = payload_q;
        // Poll decisions use the STATUS byte arriving this cycle.
        stat_d    = frm_first ? spi_data_in : stat_q;
        frm_go    = 1'b0;
        frm_len   = 6'd1;
        frm_byte  = CMD_NOP;
        case (state_q)
            S_IDLE: begin
                if (init_req) begin
                    state_d = S_INIT_XFER;
                    step_d  = 3'd0;
                end
            end
            S_READY: begin
                if (init_req) begin
                    state_d = S_INIT_XFER;
                    step_d  = 3'd0;
                end else if (tx_req) begin
                    state_d   = S_TX_XFER;
                    payload_d = tx_data;
                end
            end
            S_INIT_XFER: begin
                frm_len  = (step_q == INIT_LAST) ? 6'd1 : 6'd2;
                frm_byte = init_byte(step_q, frm_idx == 6'd0, RF_CHANNEL);
                frm_go   = frm_ready;
                if (frm_done) begin
                    if (step_q == INIT_LAST) begin
                        state_d = S_PWRUP_WAIT;
                        cnt_d   = 16'd0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_PWRUP_WAIT: begin
                if (cnt_q >= PWRUP_LAST) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = sat_inc16(cnt_q);
                end
            end
            S_TX_XFER: begin
                frm_len  = 6'(PAYLOAD_LEN + 1);
                frm_byte = CMD_W_TX_PAYLOAD;
                for (int i = 0; i < PAYLOAD_LEN; i++) begin
                    if (frm_idx == 6'(i + 1)) begin
                        frm_byte = payload_q[8*i +: 8];
                    end
                end
                frm_go = frm_ready;
                if (frm_done) begin
                    state_d = S_CE_PULSE;
                    cnt_d   = 16'd0;
                    ce_d    = 1'b1;
                end
            end
            S_CE_PULSE: begin
                if (cnt_q >= CE_LAST) begin
                    ce_d    = 1'b0;
                    state_d = S_POLL;
                    poll_d  = 16'd0;
                end else begin
                    cnt_d = sat_inc16(cnt_q);
                end
            end
            S_POLL: begin
                frm_go = frm_ready;
                if (frm_done) begin
                    poll_d = sat_inc16(poll_q);
                    // TX_DS takes priority over MAX_RT when both are set.
                    if (stat_d[STATUS_TX_DS]) begin
                        state_d = S_CLEAR;
                        step_d  = 3'd0;
                        fail_d  = 1'b0;
                    end else if (stat_d[STATUS_MAX_RT] || poll_d >= POLL_MAX) begin
                        state_d = S_CLEAR;
                        step_d  = 3'd0;
                        fail_d  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (step_q == 3'd0) begin
                    frm_len  = 6'd2;
                    frm_byte = (frm_idx == 6'd0) ? w_reg(REG_STATUS) : 8'h70;
                end else begin
                    frm_byte = CMD_FLUSH_TX;
                end
                frm_go = frm_ready;
                if (frm_done) begin
                    if (step_q == 3'd0 && fail_q) begin
                        step_d = 3'd1;
                    end else begin
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready    = (state_q == S_READY);
    assign busy     = (state_q != S_IDLE) && (state_q != S_READY);
    assign tx_ok    = (state_q == S_REPORT) && !fail_q;
    assign tx_fail  = (state_q == S_REPORT) && fail_q;
    assign status_q = stat_q;
    assign ce       = ce_q;

endmodule

// File: tb/tb_nrf_link_sequencer.sv
// Testbench for nrf_link_sequencer: an SPI byte-engine/device model answers
// each spi_start eight cycles later and checks MOSI bytes against a
// scoreboard queue filled when requests are issued.
module tb_nrf_link_sequencer;

    logic        clk_10 = 1'b0;
    logic        rst;
    logic        init_req;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        ready;
    logic        busy;
    logic        tx_ok;
    logic        tx_fail;
    logic [7:0]  status_q;
    logic [7:0]  spi_data_out;
    logic        spi_start;
    logic        spi_done;
    logic [7:0]  spi_data_in;
    logic        csn;
    logic        ce;

    always #50 clk_10 = ~clk_10;

    nrf_link_sequencer dut (
        .clk_10      (clk_10),
        .rst         (rst),
        .init_req    (init_req),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .ready       (ready),
        .busy        (busy),
        .tx_ok       (tx_ok),
        .tx_fail     (tx_fail),
        .status_q    (status_q),
        .spi_data_out(spi_data_out),
        .spi_start   (spi_start),
        .spi_done    (spi_done),
        .spi_data_in (spi_data_in),
        .csn         (csn),
        .ce          (ce)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] poll_q[$];
    logic [7:0] status_reg = 8'h0E;

    // Monitor counters: only the monitor writes them; main takes snapshots.
    int cyc = 0, frames = 0, ce_cnt = 0, ok_cnt = 0, fail_cnt = 0;
    int last_rise = 0, rdy_cyc = 0;
    logic mon_csn = 1'b1, mon_rdy = 1'b0;
    int b_frames, b_ce, b_ok, b_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_10) begin
        cyc++;
        if (!mon_csn && csn) last_rise = cyc;
        if (mon_csn && !csn) frames++;
        if (ce) ce_cnt++;
        if (tx_ok) ok_cnt++;
        if (tx_fail) fail_cnt++;
        if (!mon_rdy && ready) rdy_cyc = cyc;
        mon_csn = csn;
        mon_rdy = ready;
    end

    // SPI engine + device model.
    initial begin
        logic [7:0] b, resp, prev_b;
        logic       first, prev_csn, clear_after, abort;
        int         since_fall;
        spi_done    = 1'b0;
        spi_data_in = 8'h00;
        prev_b      = 8'h00;
        first       = 1'b0;
        prev_csn    = 1'b1;
        since_fall  = 0;
        forever begin
            @(negedge clk_10);
            if (!rst) begin
                first    = 1'b0;
                prev_csn = 1'b1;
            end else begin
                if (prev_csn && !csn) begin
                    first      = 1'b1;
                    since_fall = 0;
                end else begin
                    since_fall++;
                end
                prev_csn = csn;
                if (spi_start) begin
                    b = spi_data_out;
                    chk("csn_low_at_start", csn, 1'b0);
                    if (first) chk("csn_lead", since_fall, 1);
                    chk("mosi_pending", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk("mosi", b, exp_q.pop_front());
                    if (first && b == 8'hFF && poll_q.size() != 0) status_reg = poll_q.pop_front();
                    resp        = first ? status_reg : 8'h00;
                    clear_after = (prev_b == 8'h27 && b == 8'h70);
                    prev_b      = b;
                    first       = 1'b0;
                    abort       = 1'b0;
                    for (int k = 0; k < 7; k++) begin
                        @(negedge clk_10);
                        if (k == 0) chk("start_1cyc", spi_start, 1'b0);
                        if (!rst) abort = 1'b1;
                    end
                    if (!abort) begin
                        chk("mosi_stable", spi_data_out, b);
                        spi_data_in = resp;
                        spi_done    = 1'b1;
                        @(negedge clk_10);
                        spi_done    = 1'b0;
                        spi_data_in = 8'h00;
                        if (clear_after) status_reg = status_reg & ~8'h70;
                    end
                    prev_csn = csn;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_10);
        #1;
    endtask

    task automatic snap();
        b_frames = frames;
        b_ce     = ce_cnt;
        b_ok     = ok_cnt;
        b_fail   = fail_cnt;
    endtask

    task automatic push_init();
        logic [7:0] seq [13];
        seq = '{8'h20, 8'h0E, 8'h21, 8'h01, 8'h24, 8'h2F, 8'h25, 8'h4C,
                8'h26, 8'h06, 8'h27, 8'h70, 8'hE1};
        for (int i = 0; i < 13; i++) exp_q.push_back(seq[i]);
    endtask

    task automatic push_payload();
        exp_q.push_back(8'hA0);
        for (int i = 0; i < 4; i++) exp_q.push_back(tx_data[8*i +: 8]);
    endtask

    task automatic push_tx(input int n_polls, input logic fail);
        push_payload();
        for (int i = 0; i < n_polls; i++) exp_q.push_back(8'hFF);
        exp_q.push_back(8'h27);
        exp_q.push_back(8'h70);
        if (fail) exp_q.push_back(8'hE1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        chk(tag, ready, 1'b1);
    endtask

    task automatic run_tx(input string tag, input int n_polls, input logic fail,
                          input logic [7:0] exp_status);
        snap();
        push_tx(n_polls, fail);
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        wait_ready({tag, "_ready"}, 2000);
        chk({tag, "_ce_len"}, ce_cnt - b_ce, 150);
        chk({tag, "_ok"}, ok_cnt - b_ok, fail ? 0 : 1);
        chk({tag, "_fail"}, fail_cnt - b_fail, fail ? 1 : 0);
        chk({tag, "_status"}, status_q, exp_status);
        chk({tag, "_frames"}, frames - b_frames, n_polls + (fail ? 3 : 2));
        chk({tag, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int starts, n;
        rst      = 1'b0;
        init_req = 1'b0;
        tx_req   = 1'b0;
        tx_data  = 32'h0;
        repeat (3) tick();
        chk("rst_csn", csn, 1'b1);
        chk("rst_ce", ce, 1'b0);
        chk("rst_start", spi_start, 1'b0);
        chk("rst_mosi", spi_data_out, 8'h00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ok", tx_ok, 1'b0);
        chk("rst_fail", tx_fail, 1'b0);
        chk("rst_status", status_q, 8'h00);
        rst = 1'b1;
        repeat (2) tick();

        // Init sequence.
        snap();
        push_init();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk("init_busy", busy, 1'b1);
        wait_ready("init_ready", 20000);
        chk("init_frames", frames - b_frames, 7);
        chk("init_ready_delay", rdy_cyc - last_rise, 15000);
        chk("init_left", exp_q.size(), 0);
        chk("init_ce", ce_cnt - b_ce, 0);

        // Transmit: two empty polls then TX_DS.
        tx_data = 32'hDDCCBBAA;
        poll_q  = '{8'h0E, 8'h0E, 8'h2E};
        run_tx("tx_ok", 3, 1'b0, 8'h2E);

        // MAX_RT: clear plus flush.
        poll_q = '{8'h1E};
        run_tx("tx_maxrt", 1, 1'b1, 8'h0E);

        // Both bits set: success wins.
        poll_q = '{8'h3E};
        run_tx("tx_both", 1, 1'b0, 8'h3E);

        // Requests while busy are dropped.
        tx_data = 32'h27707A5C;
        poll_q  = '{8'h0E, 8'h2E};
        snap();
        push_tx(2, 1'b0);
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        repeat (5) tick();
        chk("drop_busy", busy, 1'b1);
        tx_req   = 1'b1;
        init_req = 1'b1;
        tick();
        tx_req   = 1'b0;
        init_req = 1'b0;
        wait_ready("drop_ready", 2000);
        chk("drop_frames", frames - b_frames, 4);
        chk("drop_left", exp_q.size(), 0);
        chk("drop_ok", ok_cnt - b_ok, 1);

        // Simultaneous init_req and tx_req in READY: init wins.
        snap();
        push_init();
        tx_req   = 1'b1;
        init_req = 1'b1;
        tick();
        tx_req   = 1'b0;
        init_req = 1'b0;
        wait_ready("both_ready", 20000);
        chk("both_frames", frames - b_frames, 7);
        chk("both_left", exp_q.size(), 0);
        chk("both_ce", ce_cnt - b_ce, 0);
        chk("both_ready_delay", rdy_cyc - last_rise, 15000);

        // Asynchronous reset in the middle of the payload transfer.
        tx_data = 32'h44332211;
        poll_q.delete();
        push_payload();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        starts = 0;
        n      = 0;
        while (starts < 2 && n < 200) begin
            if (spi_start) starts++;
            tick();
            n++;
        end
        chk("abort_reach", starts, 2);
        repeat (3) tick();
        chk("abort_pre_csn", csn, 1'b0);
        #20;
        rst = 1'b0;
        #1;
        chk("abort_csn", csn, 1'b1);
        chk("abort_ce", ce, 1'b0);
        chk("abort_start", spi_start, 1'b0);
        chk("abort_mosi", spi_data_out, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", ready, 1'b0);
        chk("abort_status", status_q, 8'h00);
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b1;
        snap();
        repeat (40) tick();
        chk("post_ready", ready, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_csn", csn, 1'b1);
        chk("post_frames", frames - b_frames, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
